// File: rtl/sipo_2bit_collect_pkg.sv
// Shared definitions for the 2-bit-per-beat serial-in/parallel-out collector.
package sipo_2bit_collect_pkg;

  // Bits carried per serial beat; matches the transmitting shifter.
  localparam int unsigned SER_W = 2;

  // Default word width and the matching beat count.
  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned BEATS     = DEF_WIDTH / SER_W;

  typedef enum logic {
    StIdle    = 1'b0,
    StCollect = 1'b1
  } state_e;

  // Number of beats needed to fill a word of the given width.
  function automatic int unsigned beats_of(input int unsigned width);
    return width / SER_W;
  endfunction

endpackage

// File: rtl/sipo_2bit_collect.sv
// Collects 2-bit beats (LSB pair first) into a WIDTH-bit word, with start/restart
// control, a one-cycle done pulse and a sticky overrun flag.
module sipo_2bit_collect
  import sipo_2bit_collect_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH / 2) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       sin,
  input  logic             sin_valid,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] pout,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  localparam int unsigned NBeats = beats_of(WIDTH);

  // The lowest pair would only be shifted out on completion, so the register keeps
  // just the upper WIDTH-SER_W bits; the full word is formed with the incoming beat.
  state_e                   state_q, state_d;
  logic [WIDTH-SER_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]         pout_q, pout_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic [WIDTH-1:0]         shifted;

  assign shifted = {sin, shreg_q};

  // Next-state: FSM, shift register, beat counter, output word and flags.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    pout_d  = pout_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCollect;
          shreg_d = '0;
          cnt_d   = '0;
        end else if (sin_valid) begin
          // Overrun set takes priority over a simultaneous clear.
          ovf_d = 1'b1;
        end
      end
      StCollect: begin
        if (start) begin
          // Restart: discard progress and this cycle's beat, keep pout.
          shreg_d = '0;
          cnt_d   = '0;
        end else if (sin_valid) begin
          shreg_d = shifted[WIDTH-1:SER_W];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NBeats - 1)) begin
            pout_d  = shifted;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      pout_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      pout_q  <= pout_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pout = pout_q;
  assign done = done_q;
  assign busy = (state_q == StCollect);
  assign ovf  = ovf_q;

endmodule
